// File: rtl/tp84_snd_pkg.sv
// Shared types for the Time Pilot '84 CPU-to-sound-board command link.
// Holds the FIFO entry format and the transmit/read state encodings.
package tp84_snd_pkg;

   typedef enum logic {
      OP_DATA = 1'b0,
      OP_IRQ  = 1'b1
   } op_t;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_SETUP,
      TX_LOW,
      TX_HOLD
   } tx_state_t;

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_ASSERT,
      RD_SAMPLE
   } rd_state_t;

   typedef struct packed {
      op_t        op;
      logic [7:0] data;
   } cmd_t;

   localparam logic [2:0] RD_SEL_IN5 = 3'd4;
   localparam cmd_t IRQ_ENTRY = '{op: OP_IRQ, data: 8'h00};

endpackage

// File: rtl/tp84_cmd_fifo.sv
// Small synchronous command FIFO with a second write port so a DATA and an
// IRQ entry can be queued in the same cycle (din first, din2 behind it).
module tp84_cmd_fifo
   import tp84_snd_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk_14m,
   input  logic          n_reset,
   input  logic          push,
   input  logic          push2,
   input  cmd_t          din,
   input  cmd_t          din2,
   input  logic          pop,
   output cmd_t          head,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   cmd_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;

   // Caller guarantees free space for every push and push2 only with push.
   always_ff @(posedge clk_14m) begin
      if (!n_reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_reg + AW'(push) + AW'(push2);
         rd_ptr_reg <= rd_ptr_reg + AW'(pop);
         count_reg  <= count_reg + CW'(push) + CW'(push2) - CW'(pop);
      end
   end

   always_ff @(posedge clk_14m) begin
      if (push)
         mem[wr_ptr_reg] <= din;
      if (push2)
         mem[wr_ptr_reg + AW'(1)] <= din2;
   end

   assign head  = mem[rd_ptr_reg];
   assign full  = (count_reg == CW'(DEPTH));
   assign empty = (count_reg == '0);
   assign count = count_reg;

endmodule

// File: rtl/tp84_snd_cmd_tx.sv
// CPU-board side of the TP84 sound link: queues latch/interrupt requests and
// replays them with fixed setup/pulse/hold, and runs the ioen/in5 read cycles.
module tp84_snd_cmd_tx
   import tp84_snd_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int SETUP   = 2,
   parameter int PULSE   = 4,
   parameter int HOLD    = 2,
   parameter int RD_WAIT = 3
) (
   input  logic       clk_14m,
   input  logic       n_reset,
   input  logic       cmd_wr,
   input  logic [7:0] cmd_data,
   input  logic       irq_wr,
   output logic       cmd_ready,
   output logic       cmd_ovf,
   output logic       tx_busy,
   input  logic       rd_req,
   input  logic [2:0] rd_sel,
   output logic       rd_ready,
   output logic       rd_valid,
   output logic [7:0] rd_data,
   output logic [7:0] cpubrd_Din,
   output logic       sound_data,
   output logic       sound_on,
   output logic       ioen,
   output logic       in5,
   output logic       cpubrd_A5,
   output logic       cpubrd_A6,
   input  logic [7:0] sndbrd_Dout
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [CW-1:0] fifo_count;
   logic          fifo_full, fifo_empty;
   cmd_t          fifo_head, push_din;
   logic          accept_data, accept_irq, push, push2, pop;

   // A paired DATA+IRQ request needs two slots; otherwise only DATA goes in.
   always_comb begin
      accept_data = cmd_wr && !fifo_full;
      accept_irq  = irq_wr && (cmd_wr ? (fifo_count <= CW'(DEPTH - 2)) : !fifo_full);
      push        = accept_data || accept_irq;
      push2       = accept_data && accept_irq;
      push_din    = accept_data ? '{op: OP_DATA, data: cmd_data} : IRQ_ENTRY;
   end

   tp84_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_14m (clk_14m),
      .n_reset (n_reset),
      .push    (push),
      .push2   (push2),
      .din     (push_din),
      .din2    (IRQ_ENTRY),
      .pop     (pop),
      .head    (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   tx_state_t  tx_state_reg, tx_state_next;
   logic [7:0] tx_cnt_reg, tx_cnt_next;
   op_t        op_reg, op_next;
   logic [7:0] din_reg, din_next;
   logic       sound_data_reg, sound_data_next;
   logic       sound_on_reg, sound_on_next;
   logic       cmd_ovf_reg;

   always_comb begin
      tx_state_next = tx_state_reg;
      tx_cnt_next   = tx_cnt_reg + 8'd1;
      op_next       = op_reg;
      din_next      = din_reg;
      pop           = 1'b0;
      case (tx_state_reg)
         TX_IDLE: begin
            tx_cnt_next = '0;
            if (!fifo_empty) begin
               pop           = 1'b1;
               op_next       = fifo_head.op;
               tx_state_next = TX_SETUP;
               if (fifo_head.op == OP_DATA)
                  din_next = fifo_head.data;
            end
         end
         TX_SETUP: if (tx_cnt_reg == 8'(SETUP - 1)) begin
            tx_state_next = TX_LOW;
            tx_cnt_next   = '0;
         end
         TX_LOW: if (tx_cnt_reg == 8'(PULSE - 1)) begin
            tx_state_next = TX_HOLD;
            tx_cnt_next   = '0;
         end
         TX_HOLD: if (tx_cnt_reg == 8'(HOLD - 1)) begin
            tx_state_next = TX_IDLE;
            tx_cnt_next   = '0;
         end
         default: tx_state_next = TX_IDLE;
      endcase
      sound_data_next = !(tx_state_next == TX_LOW && op_next == OP_DATA);
      sound_on_next   = !(tx_state_next == TX_LOW && op_next == OP_IRQ);
   end

   always_ff @(posedge clk_14m) begin
      if (!n_reset) begin
         tx_state_reg   <= TX_IDLE;
         tx_cnt_reg     <= '0;
         op_reg         <= OP_DATA;
         din_reg        <= 8'h00;
         sound_data_reg <= 1'b1;
         sound_on_reg   <= 1'b1;
         cmd_ovf_reg    <= 1'b0;
      end else begin
         tx_state_reg   <= tx_state_next;
         tx_cnt_reg     <= tx_cnt_next;
         op_reg         <= op_next;
         din_reg        <= din_next;
         sound_data_reg <= sound_data_next;
         sound_on_reg   <= sound_on_next;
         cmd_ovf_reg    <= (cmd_wr && !accept_data) || (irq_wr && !accept_irq);
      end
   end

   rd_state_t  rd_state_reg, rd_state_next;
   logic [7:0] rd_cnt_reg, rd_cnt_next;
   logic       a5_reg, a5_next, a6_reg, a6_next;
   logic       sel_in5_reg, sel_in5_next;
   logic [7:0] samp_reg, samp_next;
   logic [7:0] rd_data_reg, rd_data_next;
   logic       rd_valid_reg, rd_valid_next;
   logic       ioen_reg, ioen_next, in5_reg, in5_next, sel_low;

   // Address goes out one cycle ahead of the select so A6/A5 are settled
   // for the whole low period; the byte is captured while the select is low.
   always_comb begin
      rd_state_next = rd_state_reg;
      rd_cnt_next   = rd_cnt_reg + 8'd1;
      a5_next       = a5_reg;
      a6_next       = a6_reg;
      sel_in5_next  = sel_in5_reg;
      samp_next     = samp_reg;
      rd_data_next  = rd_data_reg;
      rd_valid_next = 1'b0;
      case (rd_state_reg)
         RD_IDLE: begin
            rd_cnt_next = '0;
            if (rd_req) begin
               if (rd_sel <= RD_SEL_IN5) begin
                  rd_state_next = RD_ASSERT;
                  a6_next       = rd_sel[1];
                  a5_next       = rd_sel[0];
                  sel_in5_next  = (rd_sel == RD_SEL_IN5);
               end else begin
                  samp_next     = 8'hFF;
                  rd_state_next = RD_SAMPLE;
               end
            end
         end
         RD_ASSERT: if (rd_cnt_reg == 8'(RD_WAIT)) begin
            samp_next     = sndbrd_Dout;
            rd_state_next = RD_SAMPLE;
         end
         RD_SAMPLE: begin
            rd_data_next  = samp_reg;
            rd_valid_next = 1'b1;
            rd_state_next = RD_IDLE;
         end
         default: rd_state_next = RD_IDLE;
      endcase
      sel_low   = (rd_state_next == RD_ASSERT) && (rd_cnt_next != '0);
      ioen_next = !(sel_low && !sel_in5_next);
      in5_next  = !(sel_low && sel_in5_next);
   end

   always_ff @(posedge clk_14m) begin
      if (!n_reset) begin
         rd_state_reg <= RD_IDLE;
         rd_cnt_reg   <= '0;
         a5_reg       <= 1'b0;
         a6_reg       <= 1'b0;
         sel_in5_reg  <= 1'b0;
         samp_reg     <= 8'hFF;
         rd_data_reg  <= 8'hFF;
         rd_valid_reg <= 1'b0;
         ioen_reg     <= 1'b1;
         in5_reg      <= 1'b1;
      end else begin
         rd_state_reg <= rd_state_next;
         rd_cnt_reg   <= rd_cnt_next;
         a5_reg       <= a5_next;
         a6_reg       <= a6_next;
         sel_in5_reg  <= sel_in5_next;
         samp_reg     <= samp_next;
         rd_data_reg  <= rd_data_next;
         rd_valid_reg <= rd_valid_next;
         ioen_reg     <= ioen_next;
         in5_reg      <= in5_next;
      end
   end

   assign cmd_ready  = !fifo_full;
   assign cmd_ovf    = cmd_ovf_reg;
   assign tx_busy    = !fifo_empty || (tx_state_reg != TX_IDLE);
   assign cpubrd_Din = din_reg;
   assign sound_data = sound_data_reg;
   assign sound_on   = sound_on_reg;
   assign rd_ready   = (rd_state_reg == RD_IDLE);
   assign rd_valid   = rd_valid_reg;
   assign rd_data    = rd_data_reg;
   assign ioen       = ioen_reg;
   assign in5        = in5_reg;
   assign cpubrd_A5  = a5_reg;
   assign cpubrd_A6  = a6_reg;

endmodule

// File: tb/tb_tp84_snd_cmd_tx.sv
// Directed bench for tp84_snd_cmd_tx: a negedge monitor logs every strobe
// pulse (kind, bus value, start cycle, width) and the tests compare the log.
module tb_tp84_snd_cmd_tx;

   logic       clk_14m = 1'b0;
   logic       n_reset = 1'b0;
   logic       cmd_wr = 1'b0, irq_wr = 1'b0, rd_req = 1'b0;
   logic [7:0] cmd_data = 8'h00, sndbrd_Dout = 8'h00;
   logic [2:0] rd_sel = 3'd0;
   logic       cmd_ready, cmd_ovf, tx_busy, rd_ready, rd_valid;
   logic [7:0] rd_data, cpubrd_Din;
   logic       sound_data, sound_on, ioen, in5, cpubrd_A5, cpubrd_A6;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int both_low = 0;

   typedef struct {
      bit         irq;
      logic [7:0] din;
      logic [7:0] din_end;
      int         start;
      int         len;
   } pulse_t;

   pulse_t pq[$];

   tp84_snd_cmd_tx dut (
      .clk_14m     (clk_14m),
      .n_reset     (n_reset),
      .cmd_wr      (cmd_wr),
      .cmd_data    (cmd_data),
      .irq_wr      (irq_wr),
      .cmd_ready   (cmd_ready),
      .cmd_ovf     (cmd_ovf),
      .tx_busy     (tx_busy),
      .rd_req      (rd_req),
      .rd_sel      (rd_sel),
      .rd_ready    (rd_ready),
      .rd_valid    (rd_valid),
      .rd_data     (rd_data),
      .cpubrd_Din  (cpubrd_Din),
      .sound_data  (sound_data),
      .sound_on    (sound_on),
      .ioen        (ioen),
      .in5         (in5),
      .cpubrd_A5   (cpubrd_A5),
      .cpubrd_A6   (cpubrd_A6),
      .sndbrd_Dout (sndbrd_Dout)
   );

   always #5 clk_14m = ~clk_14m;

   always @(posedge clk_14m) cyc++;

   logic       sd_prev = 1'b1, so_prev = 1'b1;
   int         d_start = 0, i_start = 0;
   logic [7:0] d_din = 8'h00, i_din = 8'h00;

   always @(negedge clk_14m) begin
      if (!sound_data && !sound_on) both_low++;
      if (sd_prev && !sound_data) begin d_start = cyc; d_din = cpubrd_Din; end
      if (!sd_prev && sound_data) pq.push_back('{1'b0, d_din, cpubrd_Din, d_start, cyc - d_start});
      if (so_prev && !sound_on) begin i_start = cyc; i_din = cpubrd_Din; end
      if (!so_prev && sound_on) pq.push_back('{1'b1, i_din, cpubrd_Din, i_start, cyc - i_start});
      sd_prev = sound_data;
      so_prev = sound_on;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else
         $display("ok   %s: %0h", tag, got);
   endtask

   task automatic step();
      @(posedge clk_14m);
      #1;
   endtask

   task automatic check_pulse(input string tag, input int idx, input bit irq,
                              input logic [7:0] din, input int start);
      check_eq({tag, "_kind"},  32'(pq[idx].irq), 32'(irq));
      check_eq({tag, "_din"},   32'(pq[idx].din), 32'(din));
      check_eq({tag, "_hold"},  32'(pq[idx].din_end), 32'(din));
      check_eq({tag, "_start"}, pq[idx].start, start);
      check_eq({tag, "_width"}, pq[idx].len, 4);
   endtask

   task automatic do_read(input string tag, input logic [2:0] sel, input logic [7:0] dout,
                          input logic [7:0] exp_data, input int exp_ioen, input int exp_in5,
                          input int exp_k, input logic exp_a6, input logic exp_a5);
      int n_ioen = 0, n_in5 = 0, k_valid = -1, a_bad = 0;
      logic [7:0] got = 8'h00;
      sndbrd_Dout = dout;
      rd_sel = sel;
      rd_req = 1'b1;
      step();
      rd_req = 1'b0;
      check_eq({tag, "_busy"}, 32'(rd_ready), 32'd0);
      for (int k = 1; k <= 10; k++) begin
         step();
         if (!ioen) n_ioen++;
         if (!in5) n_in5++;
         if ((!ioen || !in5) && (cpubrd_A6 !== exp_a6 || cpubrd_A5 !== exp_a5)) a_bad++;
         if (rd_valid) begin k_valid = k; got = rd_data; end
      end
      check_eq({tag, "_ioen_low"}, n_ioen, exp_ioen);
      check_eq({tag, "_in5_low"}, n_in5, exp_in5);
      check_eq({tag, "_valid_cyc"}, k_valid, exp_k);
      check_eq({tag, "_data"}, 32'(got), 32'(exp_data));
      check_eq({tag, "_addr_stable"}, a_bad, 0);
   endtask

   initial begin
      int req;
      int ovf_cnt;

      // Reset values
      repeat (3) step();
      check_eq("rst_sound_data", 32'(sound_data), 32'd1);
      check_eq("rst_sound_on", 32'(sound_on), 32'd1);
      check_eq("rst_ioen", 32'(ioen), 32'd1);
      check_eq("rst_in5", 32'(in5), 32'd1);
      check_eq("rst_a6a5", 32'({cpubrd_A6, cpubrd_A5}), 32'd0);
      check_eq("rst_din", 32'(cpubrd_Din), 32'h00);
      check_eq("rst_rd_data", 32'(rd_data), 32'hFF);
      check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
      check_eq("rst_cmd_ovf", 32'(cmd_ovf), 32'd0);
      check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check_eq("rst_tx_busy", 32'(tx_busy), 32'd0);
      check_eq("rst_rd_ready", 32'(rd_ready), 32'd1);
      n_reset = 1'b1;
      step();
      pq.delete();

      // Single DATA op
      cmd_data = 8'h5A; cmd_wr = 1'b1;
      step();
      cmd_wr = 1'b0; req = cyc;
      check_eq("data_busy", 32'(tx_busy), 32'd1);
      repeat (8) step();
      check_eq("data_busy_hold", 32'(tx_busy), 32'd1);
      step();
      check_eq("data_idle", 32'(tx_busy), 32'd0);
      repeat (2) step();
      check_eq("data_count", pq.size(), 1);
      check_pulse("data", 0, 1'b0, 8'h5A, req + 3);

      // IRQ alone keeps the previous bus value
      pq.delete();
      irq_wr = 1'b1;
      step();
      irq_wr = 1'b0; req = cyc;
      repeat (12) step();
      check_eq("irq_count", pq.size(), 1);
      check_pulse("irq", 0, 1'b1, 8'h5A, req + 3);

      // DATA and IRQ in the same cycle
      pq.delete();
      cmd_data = 8'h11; cmd_wr = 1'b1; irq_wr = 1'b1;
      step();
      cmd_wr = 1'b0; irq_wr = 1'b0; req = cyc;
      check_eq("pair_ovf", 32'(cmd_ovf), 32'd0);
      repeat (22) step();
      check_eq("pair_count", pq.size(), 2);
      check_pulse("pair_data", 0, 1'b0, 8'h11, req + 3);
      check_pulse("pair_irq", 1, 1'b1, 8'h11, req + 12);

      // Overflow: six pushes into a four-deep FIFO
      pq.delete();
      ovf_cnt = 0;
      req = 0;
      for (int i = 1; i <= 6; i++) begin
         cmd_data = 8'(i); cmd_wr = 1'b1;
         step();
         if (i == 1) req = cyc;
         if (i == 5) check_eq("ovf_full_ready", 32'(cmd_ready), 32'd0);
         if (cmd_ovf) ovf_cnt++;
      end
      cmd_wr = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (cmd_ovf) ovf_cnt++;
      end
      check_eq("ovf_pulses", ovf_cnt, 1);
      check_eq("ovf_count", pq.size(), 5);
      for (int i = 0; i < 5; i++)
         check_pulse($sformatf("ovf_%0d", i + 1), i, 1'b0, 8'(i + 1), req + 3 + 9 * i);
      check_eq("ovf_ready", 32'(cmd_ready), 32'd1);

      // Read cycles
      do_read("rd_ioen3", 3'd3, 8'hC3, 8'hC3, 3, 0, 5, 1'b1, 1'b1);
      do_read("rd_in5", 3'd4, 8'h3C, 8'h3C, 0, 3, 5, 1'b0, 1'b0);
      do_read("rd_bad6", 3'd6, 8'h12, 8'hFF, 0, 0, 1, 1'b0, 1'b0);

      // Reset while a strobe is low
      pq.delete();
      cmd_data = 8'h77; cmd_wr = 1'b1; irq_wr = 1'b1;
      step();
      cmd_wr = 1'b0; irq_wr = 1'b0;
      repeat (4) step();
      check_eq("mid_low_strobe", 32'(sound_data), 32'd0);
      n_reset = 1'b0;
      step();
      check_eq("mid_rst_strobe", 32'(sound_data), 32'd1);
      check_eq("mid_rst_ready", 32'(cmd_ready), 32'd1);
      check_eq("mid_rst_busy", 32'(tx_busy), 32'd0);
      n_reset = 1'b1;
      step();
      pq.delete();
      repeat (15) step();
      check_eq("mid_rst_flushed", pq.size(), 0);
      check_eq("mid_rst_irq_high", 32'(sound_on), 32'd1);

      check_eq("no_overlap", both_low, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
